// File: rtl/i2s_rx_param.sv
// I2S / left-justified slave receiver: oversamples bck/lrck/data_in on mck and emits aligned stereo pairs.
// Latency: data_rdy SYNC_STAGES+2 mck after the right-LSB bck edge; no backpressure, each pair is a 1-mck pulse.
module i2s_rx_param #(
    parameter int DATA_W      = 24,
    parameter int SLOT_W      = 32,
    parameter int FMT         = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              mck,
    input  logic              rst_n,
    input  logic              bck,
    input  logic              lrck,
    input  logic              data_in,
    output logic [DATA_W-1:0] left_out,
    output logic [DATA_W-1:0] right_out,
    output logic              data_rdy,
    output logic [6:0]        count,
    output logic              frame_err
);

    typedef enum logic [1:0] {WAIT_SYNC, SHIFT, PAD} state_t;

    localparam logic [6:0] SLOT_C = 7'(SLOT_W);
    // Count value at which the last data bit has been shifted in.
    localparam logic [6:0] DONE_C = 7'(DATA_W - FMT);

    logic [SYNC_STAGES-1:0] bck_sync, lrck_sync, data_sync;
    logic                   bck_s, lrck_s, data_s;
    logic                   bck_d, lrck_q, bck_rise, lr_edge;

    state_t            state, state_n;
    logic [6:0]        count_n, count_inc;
    logic [DATA_W-1:0] sreg, sreg_n, left_hold, left_hold_n, shifted;
    logic              chan, chan_n;
    logic              left_vld, left_vld_n;
    logic              commit, commit_n;
    logic              err_n;

    always_ff @(posedge mck) begin
        if (!rst_n) begin
            bck_sync  <= '0;
            lrck_sync <= '0;
            data_sync <= '0;
        end else begin
            bck_sync  <= {bck_sync[SYNC_STAGES-2:0], bck};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
            data_sync <= {data_sync[SYNC_STAGES-2:0], data_in};
        end
    end

    assign bck_s    = bck_sync[SYNC_STAGES-1];
    assign lrck_s   = lrck_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign bck_rise = bck_s & ~bck_d;
    assign lr_edge  = lrck_s != lrck_q;

    assign count_inc = (count < SLOT_C) ? count + 7'd1 : count;
    assign shifted   = {sreg[DATA_W-2:0], data_s};

    always_comb begin
        state_n     = state;
        count_n     = count;
        sreg_n      = sreg;
        chan_n      = chan;
        left_hold_n = left_hold;
        left_vld_n  = left_vld;
        commit_n    = 1'b0;
        err_n       = 1'b0;
        if (bck_rise) begin
            if (lr_edge) begin
                // A slot boundary always wins, even when count has just reached SLOT_W.
                if (state == SHIFT) begin
                    err_n = 1'b1;
                end
                state_n = SHIFT;
                count_n = '0;
                chan_n  = lrck_s;
                if (!lrck_s) begin
                    left_vld_n = 1'b0;
                end
                if (FMT == 1) begin
                    sreg_n = shifted;
                end
            end else begin
                case (state)
                    WAIT_SYNC: count_n = '0;
                    SHIFT: begin
                        count_n = count_inc;
                        sreg_n  = shifted;
                        if (count_inc == DONE_C) begin
                            state_n = PAD;
                            if (!chan) begin
                                left_hold_n = shifted;
                                left_vld_n  = 1'b1;
                            end else begin
                                commit_n   = left_vld;
                                left_vld_n = 1'b0;
                            end
                        end
                    end
                    PAD: begin
                        if (count_inc == SLOT_C) begin
                            err_n   = 1'b1;
                            state_n = WAIT_SYNC;
                            count_n = '0;
                        end else begin
                            count_n = count_inc;
                        end
                    end
                    default: state_n = WAIT_SYNC;
                endcase
            end
        end
    end

    always_ff @(posedge mck) begin
        if (!rst_n) begin
            state     <= WAIT_SYNC;
            count     <= '0;
            sreg      <= '0;
            chan      <= 1'b0;
            left_hold <= '0;
            left_vld  <= 1'b0;
            commit    <= 1'b0;
            bck_d     <= 1'b0;
            lrck_q    <= 1'b0;
            left_out  <= '0;
            right_out <= '0;
            data_rdy  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            sreg      <= sreg_n;
            chan      <= chan_n;
            left_hold <= left_hold_n;
            left_vld  <= left_vld_n;
            commit    <= commit_n;
            bck_d     <= bck_s;
            if (bck_rise) begin
                lrck_q <= lrck_s;
            end
            frame_err <= err_n;
            data_rdy  <= commit;
            // sreg is stable here: mck runs at least 4x bck, so no rise follows the completing one.
            if (commit) begin
                left_out  <= left_hold;
                right_out <= sreg;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_param.sv
module tb_i2s_rx_param;

    logic mck = 1'b0;
    logic rst_n = 1'b0;
    logic bck_a = 1'b0, lrck_a = 1'b0, din_a = 1'b0;
    logic bck_b = 1'b0, lrck_b = 1'b0, din_b = 1'b0;

    logic [23:0] l0, r0, l1, r1;
    logic [15:0] l2, r2;
    logic        rdy0, rdy1, rdy2, ferr0, ferr1, ferr2;
    logic [6:0]  cnt0, cnt1, cnt2;

    always #5 mck = ~mck;

    i2s_rx_param #(.DATA_W(24), .SLOT_W(32), .FMT(0), .SYNC_STAGES(2)) dut0 (
        .mck(mck), .rst_n(rst_n), .bck(bck_a), .lrck(lrck_a), .data_in(din_a),
        .left_out(l0), .right_out(r0), .data_rdy(rdy0), .count(cnt0), .frame_err(ferr0));
    i2s_rx_param #(.DATA_W(24), .SLOT_W(32), .FMT(1), .SYNC_STAGES(2)) dut1 (
        .mck(mck), .rst_n(rst_n), .bck(bck_a), .lrck(lrck_a), .data_in(din_a),
        .left_out(l1), .right_out(r1), .data_rdy(rdy1), .count(cnt1), .frame_err(ferr1));
    i2s_rx_param #(.DATA_W(16), .SLOT_W(16), .FMT(1), .SYNC_STAGES(2)) dut2 (
        .mck(mck), .rst_n(rst_n), .bck(bck_b), .lrck(lrck_b), .data_in(din_b),
        .left_out(l2), .right_out(r2), .data_rdy(rdy2), .count(cnt2), .frame_err(ferr2));

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
    } pair_t;

    typedef struct {
        logic        lj;
        logic [23:0] l, r, el0, er0, el1, er1;
    } vec_t;

    pair_t q0[$], q1[$], q2[$];
    vec_t  vt[8];
    int    n_tests = 0, n_fail = 0;
    int    ferr_cnt0 = 0, ferr_cnt1 = 0, ferr_cnt2 = 0, n2 = 0;
    time   t_lsb0 = 0, t_lsb1 = 0;
    localparam time LAT = 40;  // (SYNC_STAGES+2) mck periods, bck edges aligned to mck falling edges

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input int s, input logic lr, input logic d, input int mark);
        if (s == 0) begin bck_a = 1'b0; lrck_a = lr; din_a = d; end
        else        begin bck_b = 1'b0; lrck_b = lr; din_b = d; end
        #40;
        if (s == 0) bck_a = 1'b1;
        else        bck_b = 1'b1;
        if (mark == 1) t_lsb0 = $time;
        if (mark == 2) t_lsb1 = $time;
        #40;
        if (s == 0) bck_a = 1'b0;
        else        bck_b = 1'b0;
    endtask

    task automatic send_slot(input int s, input logic lr, input logic [31:0] w, input logic lj,
                             input int dw, input int sw);
        for (int p = 0; p < sw; p++) begin
            int   idx;
            int   mk;
            logic d;
            idx = lj ? dw - 1 - p : dw - p;
            d   = (idx >= 0 && idx < dw) ? w[idx] : 1'b0;
            mk  = 0;
            if (s == 0 && lr) begin
                if (p == dw)          mk = 1;
                else if (p == dw - 1) mk = 2;
            end
            send_bit(s, lr, d, mk);
        end
    endtask

    task automatic send_frame(input int s, input logic [31:0] l, input logic [31:0] r,
                              input logic lj, input int dw, input int sw);
        send_slot(s, 1'b0, l, lj, dw, sw);
        send_slot(s, 1'b1, r, lj, dw, sw);
    endtask

    task automatic do_reset();
        @(negedge mck) rst_n = 1'b0;
        @(negedge mck) rst_n = 1'b1;
    endtask

    task automatic push01(input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1);
        pair_t e;
        e.l = a0; e.r = b0; q0.push_back(e);
        e.l = a1; e.r = b1; q1.push_back(e);
    endtask

    always @(negedge mck) begin : mon0
        pair_t e;
        if (rdy0) begin
            if (q0.size() == 0) check("rdy0_unexpected", 64'd1, 64'd0);
            else begin
                e = q0.pop_front();
                check("left0", 64'(l0), 64'(e.l));
                check("right0", 64'(r0), 64'(e.r));
                check("lat0", 64'($time - t_lsb0), 64'(LAT));
            end
        end
        if (ferr0) ferr_cnt0++;
    end

    always @(negedge mck) begin : mon1
        pair_t e;
        if (rdy1) begin
            if (q1.size() == 0) check("rdy1_unexpected", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                check("left1", 64'(l1), 64'(e.l));
                check("right1", 64'(r1), 64'(e.r));
                check("lat1", 64'($time - t_lsb1), 64'(LAT));
            end
        end
        if (ferr1) ferr_cnt1++;
    end

    always @(negedge mck) begin : mon2
        pair_t e;
        if (rdy2) begin
            if (q2.size() == 0) check("rdy2_unexpected", 64'd1, 64'd0);
            else begin
                e = q2.pop_front();
                check("left2", 64'(l2), 64'(e.l));
                check("right2", 64'(r2), 64'(e.r));
                n2++;
            end
        end
        if (ferr2) ferr_cnt2++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic        prev_lj;
        int          e0, e1, e2;
        logic [31:0] wl, wr;

        // {lj, left, right, dut0 left/right, dut1 left/right}
        vt[0] = '{1'b0, 24'h888888, 24'h123456, 24'h888888, 24'h123456, 24'h444444, 24'h091A2B};
        vt[1] = vt[0];
        vt[2] = vt[0];
        vt[3] = vt[0];
        vt[4] = '{1'b0, 24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A, 24'h52D2D2, 24'h2D2D2D};
        vt[5] = '{1'b1, 24'h888888, 24'h123456, 24'h111110, 24'h2468AC, 24'h888888, 24'h123456};
        vt[6] = '{1'b1, 24'hFFFFFF, 24'h000001, 24'hFFFFFE, 24'h000002, 24'hFFFFFF, 24'h000001};
        vt[7] = '{1'b1, 24'h800001, 24'h7FFFFE, 24'h000002, 24'hFFFFFC, 24'h800001, 24'h7FFFFE};

        do_reset();
        check("rst_l0", 64'(l0), 0);
        check("rst_r0", 64'(r0), 0);
        check("rst_rdy0", 64'(rdy0), 0);
        check("rst_cnt0", 64'(cnt0), 0);
        check("rst_ferr0", 64'(ferr0), 0);
        check("rst_l2", 64'(l2), 0);
        check("rst_cnt2", 64'(cnt2), 0);

        // Table: I2S and left-justified streams into both 24-bit receivers.
        prev_lj = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || vt[i].lj != prev_lj) begin
                do_reset();
                send_slot(0, 1'b1, 32'h0, vt[i].lj, 24, 32);
            end
            prev_lj = vt[i].lj;
            push01(32'(vt[i].el0), 32'(vt[i].er0), 32'(vt[i].el1), 32'(vt[i].er1));
            send_frame(0, 32'(vt[i].l), 32'(vt[i].r), vt[i].lj, 24, 32);
        end
        repeat (4) @(negedge mck);
        check("drain_table0", 64'(q0.size()), 0);
        check("drain_table1", 64'(q1.size()), 0);

        // Reset pulse in the middle of a right slot.
        do_reset();
        send_slot(0, 1'b1, 32'h0, 1'b0, 24, 32);
        push01(32'h111111, 32'h222222, 32'h088888, 32'h111111);
        send_frame(0, 32'h111111, 32'h222222, 1'b0, 24, 32);
        send_slot(0, 1'b0, 32'h333333, 1'b0, 24, 32);
        fork
            send_slot(0, 1'b1, 32'h444444, 1'b0, 24, 32);
            begin
                #800;
                do_reset();
                check("mid_rst_l0", 64'(l0), 0);
                check("mid_rst_r0", 64'(r0), 0);
                check("mid_rst_l1", 64'(l1), 0);
                check("mid_rst_r1", 64'(r1), 0);
                check("mid_rst_cnt0", 64'(cnt0), 0);
                check("mid_rst_rdy0", 64'(rdy0), 0);
            end
        join
        push01(32'h555555, 32'h666666, 32'h2AAAAA, 32'h333333);
        send_frame(0, 32'h555555, 32'h666666, 1'b0, 24, 32);

        // Short left slot: framing error, no pair, outputs kept.
        push01(32'hC3C3C3, 32'h3C3C3C, 32'h61E1E1, 32'h1E1E1E);
        send_frame(0, 32'hC3C3C3, 32'h3C3C3C, 1'b0, 24, 32);
        e0 = ferr_cnt0;
        e1 = ferr_cnt1;
        send_slot(0, 1'b0, 32'h777777, 1'b0, 24, 16);
        send_slot(0, 1'b1, 32'h999999, 1'b0, 24, 32);
        check("short_ferr0", 64'(ferr_cnt0 - e0), 1);
        check("short_ferr1", 64'(ferr_cnt1 - e1), 1);
        check("hold_l0", 64'(l0), 64'h C3C3C3);
        check("hold_r0", 64'(r0), 64'h3C3C3C);
        check("hold_l1", 64'(l1), 64'h61E1E1);
        push01(32'h0F0F0F, 32'hF0F0F0, 32'h078787, 32'h787878);
        send_frame(0, 32'h0F0F0F, 32'hF0F0F0, 1'b0, 24, 32);

        // lrck held for 40 bck: word still commits, then overrun error and resync.
        push01(32'h135790, 32'h2468AC, 32'h09ABC8, 32'h123456);
        e0 = ferr_cnt0;
        e1 = ferr_cnt1;
        send_slot(0, 1'b0, 32'h135790, 1'b0, 24, 32);
        send_slot(0, 1'b1, 32'h2468AC, 1'b0, 24, 40);
        check("long_ferr0", 64'(ferr_cnt0 - e0), 1);
        check("long_ferr1", 64'(ferr_cnt1 - e1), 1);
        check("long_cnt0", 64'(cnt0), 0);
        check("long_cnt1", 64'(cnt1), 0);
        push01(32'hABCDEF, 32'h012345, 32'h55E6F7, 32'h0091A2);
        send_frame(0, 32'hABCDEF, 32'h012345, 1'b0, 24, 32);
        repeat (4) @(negedge mck);
        check("drain_seq0", 64'(q0.size()), 0);
        check("drain_seq1", 64'(q1.size()), 0);

        // Back-to-back random 16-bit LJ words, slot exactly one word long.
        do_reset();
        e2 = ferr_cnt2;
        send_slot(1, 1'b1, 32'h0, 1'b1, 16, 16);
        for (int f = 0; f < 100; f++) begin
            pair_t e;
            wl = 32'($urandom_range(0, 65535));
            wr = 32'($urandom_range(0, 65535));
            e.l = wl;
            e.r = wr;
            q2.push_back(e);
            send_frame(1, wl, wr, 1'b1, 16, 16);
        end
        repeat (6) @(negedge mck);
        check("rand_pairs", 64'(n2), 100);
        check("rand_drain", 64'(q2.size()), 0);
        check("rand_ferr", 64'(ferr_cnt2 - e2), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
